pdu_input_conditioner: RTL and testbench
========================================

PDU_INPUT_CONDITIONER -- requirements
Module: pdu_input_conditioner

Interface
REQ-001 Parameter DB_LIMIT, default 1000000, stable-sample count required to accept a new input level (10 ms at 100 MHz).
REQ-002 Parameter REP_DELAY, default 50000000, step hold time in cycles before auto-repeat starts (used only with PDU_STEP_AUTOREPEAT_EN).
REQ-003 Parameter REP_HALF, default 10000000, auto-repeat half-period in cycles (used only with PDU_STEP_AUTOREPEAT_EN).
REQ-004 clk  input  1  system clock (100 MHz board clock).
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 raw_run  input  1  run switch, asynchronous to clk.
REQ-007 raw_step  input  1  step push-button, asynchronous, bouncing.
REQ-008 raw_valid  input  1  valid switch, asynchronous, bouncing.
REQ-009 raw_in  input  5  data/address switches, asynchronous, bouncing.
REQ-010 run  output  1  debounced run level to PDU.
REQ-011 step  output  1  debounced (optionally auto-repeated) step level to PDU.
REQ-012 valid  output  1  debounced valid level to PDU.
REQ-013 in  output  5  debounced switch value to PDU.
REQ-014 in_chg  output  1  one-cycle pulse when any bit of in updates.

Function
REQ-015 Each of the 8 input bits SHALL pass through its own 2-flop synchronizer before any other logic.
REQ-016 Each bit SHALL have an independent debounce counter, width ceil(log2(DB_LIMIT)), and a registered stable level.
REQ-017 Synchronized bit equal to stable level -> counter cleared to 0 that cycle.
REQ-018 Synchronized bit differs -> counter increments; on the edge where counter == DB_LIMIT-1 and mismatch still holds, stable level takes the new value and counter clears.
REQ-019 Any bounce (return to stable value) before DB_LIMIT consecutive mismatching samples SHALL discard the pending change; no partial credit.
REQ-020 Latency raw change -> output change SHALL be DB_LIMIT+2 clk cycles (+0/+1 for raw sampling phase).
REQ-021 Counters SHALL saturate/clear and never wrap while a mismatch persists.
REQ-022 run, valid, in SHALL be the registered stable levels directly; step SHALL be the stable level unless auto-repeat is active.
REQ-023 in_chg SHALL be high for exactly one cycle, coincident with the first cycle in shows a new value; several in bits updating on the same edge yield one pulse.
REQ-024 Bits are independent: simultaneous changes on multiple channels SHALL each complete on their own counter.

Reset
REQ-025 rst high SHALL immediately clear synchronizers, counters, stable levels and repeat state; run=0, step=0, valid=0, in=5'b00000, in_chg=0.
REQ-026 Reset asserted mid-debounce SHALL abandon the pending change; after release, a still-different raw input restarts from count 0.
REQ-027 After reset release, a raw input already high SHALL appear at the output DB_LIMIT+2 cycles later, exactly as a fresh change.

Configuration
REQ-028 Macro PDU_STEP_AUTOREPEAT_EN defined: step uses FSM IDLE/HELD/REP_LO/REP_HI.
REQ-029 IDLE: step=0; stable step rises -> HELD, step=1, timer cleared.
REQ-030 HELD: step=1; timer reaches REP_DELAY-1 -> REP_LO, timer cleared.
REQ-031 REP_LO: step=0 for REP_HALF cycles -> REP_HI; REP_HI: step=1 for REP_HALF cycles -> REP_LO.
REQ-032 Stable step falling in any state SHALL force IDLE and step=0 on the same edge the stable level falls.
REQ-033 Macro not defined: no FSM or timer is synthesized; step equals stable step level; REP_DELAY/REP_HALF ignored.

Verification (DB_LIMIT=4, REP_DELAY=20, REP_HALF=5)
REQ-034 Clean raw_in 0->5'h15 held -> in=5'h15 after 6-7 cycles, in_chg pulses exactly once.
REQ-035 raw_valid 0->1 for 3 cycles, back to 0, then 1 held -> valid stays 0 during glitch, rises 6-7 cycles after final rise.
REQ-036 rst asserted 2 cycles after raw_run rises, released 1 cycle later -> run=0 throughout, rises DB_LIMIT+2 cycles after release.
REQ-037 raw_step held 60 cycles, macro on -> step high 20 cycles, then toggles 5 low/5 high; drops to 0 when stable step falls, FSM in IDLE.
REQ-038 Same stimulus, macro off -> step high continuously for 60 cycles, one rising edge only.
REQ-039 raw_in bits 0 and 4 change 2 cycles apart -> two separate in updates and two in_chg pulses, 2 cycles apart.

Source files
------------

// File: rtl/pdu_input_conditioner.sv
// Synchronizes and debounces the PDU front-panel inputs; optional step auto-repeat under PDU_STEP_AUTOREPEAT_EN.
// Latency DB_LIMIT+2 clk from raw change to output (+0/+1 sampling phase); no backpressure, outputs are levels.
module pdu_input_conditioner #(
   parameter int DB_LIMIT  = 1000000,
   parameter int REP_DELAY = 50000000,
   parameter int REP_HALF  = 10000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       raw_run,
   input  logic       raw_step,
   input  logic       raw_valid,
   input  logic [4:0] raw_in,
   output logic       run,
   output logic       step,
   output logic       valid,
   output logic [4:0] in,
   output logic       in_chg
);

   localparam int NB = 8;
   localparam int CW = (DB_LIMIT > 1) ? $clog2(DB_LIMIT) : 1;
   localparam logic [CW-1:0] DB_MAX = CW'(DB_LIMIT - 1);

   // Channel packing: [7] run, [6] step, [5] valid, [4:0] in
   logic [NB-1:0] w_raw;
   logic [NB-1:0] r_sync1;
   logic [NB-1:0] r_sync2;
   logic [NB-1:0] r_stable;
   logic [NB-1:0] w_stable_nxt;
   logic [CW-1:0] r_cnt      [NB];
   logic [CW-1:0] w_cnt_nxt  [NB];
   logic          r_in_chg;
   logic          w_in_upd;

   assign w_raw = {raw_run, raw_step, raw_valid, raw_in};

   // A level is accepted only after DB_LIMIT consecutive mismatching samples;
   // any matching sample in between drops the count back to zero.
   always_comb begin
      w_stable_nxt = r_stable;
      for (int b = 0; b < NB; b++) begin
         w_cnt_nxt[b] = '0;
         if (r_sync2[b] != r_stable[b]) begin
            if (r_cnt[b] == DB_MAX) begin
               w_stable_nxt[b] = r_sync2[b];
            end else begin
               w_cnt_nxt[b] = r_cnt[b] + 1'b1;
            end
         end
      end
   end

   assign w_in_upd = |(w_stable_nxt[4:0] ^ r_stable[4:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_stable <= '0;
         r_in_chg <= 1'b0;
         for (int b = 0; b < NB; b++) begin
            r_cnt[b] <= '0;
         end
      end else begin
         r_sync1  <= w_raw;
         r_sync2  <= r_sync1;
         r_stable <= w_stable_nxt;
         r_in_chg <= w_in_upd;
         for (int b = 0; b < NB; b++) begin
            r_cnt[b] <= w_cnt_nxt[b];
         end
      end
   end

   assign run    = r_stable[7];
   assign valid  = r_stable[5];
   assign in     = r_stable[4:0];
   assign in_chg = r_in_chg;

`ifdef PDU_STEP_AUTOREPEAT_EN
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HELD,
      ST_REP_LO,
      ST_REP_HI
   } rep_state_t;

   localparam int TMAX = (REP_DELAY > REP_HALF) ? REP_DELAY : REP_HALF;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [TW-1:0] DELAY_END = TW'(REP_DELAY - 1);
   localparam logic [TW-1:0] HALF_END  = TW'(REP_HALF - 1);

   rep_state_t    r_state;
   rep_state_t    w_state_nxt;
   logic [TW-1:0] r_tmr;
   logic [TW-1:0] w_tmr_nxt;

   // Driven from the next stable level so the FSM moves on the same edge the level does.
   always_comb begin
      w_state_nxt = r_state;
      w_tmr_nxt   = r_tmr + 1'b1;
      if (!w_stable_nxt[6]) begin
         w_state_nxt = ST_IDLE;
         w_tmr_nxt   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_HELD;
               w_tmr_nxt   = '0;
            end
            ST_HELD: begin
               if (r_tmr == DELAY_END) begin
                  w_state_nxt = ST_REP_LO;
                  w_tmr_nxt   = '0;
               end
            end
            ST_REP_LO: begin
               if (r_tmr == HALF_END) begin
                  w_state_nxt = ST_REP_HI;
                  w_tmr_nxt   = '0;
               end
            end
            ST_REP_HI: begin
               if (r_tmr == HALF_END) begin
                  w_state_nxt = ST_REP_LO;
                  w_tmr_nxt   = '0;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_tmr_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_tmr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_tmr   <= w_tmr_nxt;
      end
   end

   assign step = (r_state == ST_HELD) || (r_state == ST_REP_HI);
`else
   logic w_unused_rep;

   assign w_unused_rep = (REP_DELAY > 0) ^ (REP_HALF > 0);
   assign step         = r_stable[6];
`endif

endmodule

// File: tb/tb_pdu_input_conditioner.sv
// Directed bench for pdu_input_conditioner with DB_LIMIT=4, REP_DELAY=20, REP_HALF=5.
module tb_pdu_input_conditioner;

   localparam int DBL = 4;
   localparam int RD  = 20;
   localparam int RH  = 5;
   localparam int LAT = DBL + 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       raw_run;
   logic       raw_step;
   logic       raw_valid;
   logic [4:0] raw_in;
   logic       run;
   logic       step;
   logic       valid;
   logic [4:0] in;
   logic       in_chg;

   int   checks  = 0;
   int   errors  = 0;
   int   chg_cnt = 0;
   int   rises   = 0;
   int   c0;
   logic prev_step = 1'b0;

   always #5 clk = ~clk;

   pdu_input_conditioner #(
      .DB_LIMIT (DBL),
      .REP_DELAY(RD),
      .REP_HALF (RH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .raw_run  (raw_run),
      .raw_step (raw_step),
      .raw_valid(raw_valid),
      .raw_in   (raw_in),
      .run      (run),
      .step     (step),
      .valid    (valid),
      .in       (in),
      .in_chg   (in_chg)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (in_chg === 1'b1) chg_cnt++;
      if (step === 1'b1 && prev_step === 1'b0) rises++;
      prev_step = step;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   function automatic logic exp_step(input int k);
      if (k < LAT || k >= 60 + LAT) return 1'b0;
`ifdef PDU_STEP_AUTOREPEAT_EN
      if (k < LAT + RD) return 1'b1;
      return (((k - LAT - RD) / RH) % 2) == 1;
`else
      return 1'b1;
`endif
   endfunction

   initial begin
      rst       = 1'b1;
      raw_run   = 1'b1;
      raw_step  = 1'b1;
      raw_valid = 1'b1;
      raw_in    = 5'h1f;
      ticks(8);
      chk("rst_run", run, 0);
      chk("rst_step", step, 0);
      chk("rst_valid", valid, 0);
      chk("rst_in", in, 0);
      chk("rst_in_chg", in_chg, 0);

      raw_run   = 1'b0;
      raw_step  = 1'b0;
      raw_valid = 1'b0;
      raw_in    = 5'h00;
      ticks(2);
      rst = 1'b0;
      ticks(8);
      chk("idle_in", in, 0);
      chk("idle_chg_cnt", chg_cnt, 0);

      // Clean 0 -> 0x15 on the data switches
      c0 = chg_cnt;
      raw_in = 5'h15;
      ticks(LAT - 1);
      chk("a_in_early", in, 5'h00);
      tick();
      chk("a_in_new", in, 5'h15);
      chk("a_chg_hi", in_chg, 1);
      tick();
      chk("a_chg_lo", in_chg, 0);
      chk("a_in_hold", in, 5'h15);
      ticks(6);
      chk("a_pulses", chg_cnt - c0, 1);

      // Bit 0 then bit 4 change two cycles apart
      c0 = chg_cnt;
      raw_in = 5'h14;
      ticks(2);
      raw_in = 5'h04;
      ticks(3);
      chk("b_in_early", in, 5'h15);
      tick();
      chk("b_in_bit0", in, 5'h14);
      chk("b_chg0_hi", in_chg, 1);
      tick();
      chk("b_chg0_lo", in_chg, 0);
      chk("b_in_mid", in, 5'h14);
      tick();
      chk("b_in_bit4", in, 5'h04);
      chk("b_chg4_hi", in_chg, 1);
      tick();
      chk("b_chg4_lo", in_chg, 0);
      ticks(4);
      chk("b_pulses", chg_cnt - c0, 2);

      // Valid glitch one sample short of acceptance, then a held rise
      raw_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) raw_valid = 1'b0;
         tick();
         chk("c_glitch_valid", valid, 0);
      end
      raw_valid = 1'b1;
      for (int i = 0; i < LAT - 1; i++) begin
         tick();
         chk("c_valid_early", valid, 0);
      end
      tick();
      chk("c_valid_rise", valid, 1);

      // Reset in the middle of a run debounce
      raw_run = 1'b1;
      ticks(2);
      rst = 1'b1;
      #1;
      chk("d_rst_run", run, 0);
      chk("d_rst_valid", valid, 0);
      chk("d_rst_in", in, 0);
      tick();
      chk("d_rst_run2", run, 0);
      rst = 1'b0;
      c0 = chg_cnt;
      for (int i = 0; i < LAT - 1; i++) begin
         tick();
         chk("d_run_early", run, 0);
      end
      tick();
      chk("d_run_rise", run, 1);
      chk("d_valid_back", valid, 1);
      chk("d_in_back", in, 5'h04);
      chk("d_in_chg", in_chg, 1);
      tick();
      chk("d_pulses", chg_cnt - c0, 1);

      // Step held 60 cycles
      ticks(4);
      c0 = rises;
      raw_step = 1'b1;
      for (int k = 1; k <= 75; k++) begin
         if (k == 61) raw_step = 1'b0;
         tick();
         chk($sformatf("e_step_k%0d", k), step, exp_step(k));
      end
`ifdef PDU_STEP_AUTOREPEAT_EN
      chk("e_rises", rises - c0, 5);
`else
      chk("e_rises", rises - c0, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
